// File: rtl/param_pkg.sv
// param_pkg: shared widths, AR control packing and arbiter state encoding
package param_pkg;
  localparam int ID_WIDTH   = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;
  localparam int RESP_WIDTH = 4;
  localparam int AR_CTRL_W  = 22;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA, ARB_RACK} arb_state_t;
endpackage

// File: rtl/ace_ar_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting just after the last grant
module rr_pick #(
  parameter int NUM_CPU = 2,
  parameter int GW      = $clog2(NUM_CPU)
) (
  input  logic [NUM_CPU-1:0] req,
  input  logic [GW-1:0]      last,
  output logic               any,
  output logic [GW-1:0]      idx
);
  logic [GW-1:0] c;
  // Scanning farthest-first lets the nearest requester overwrite the result.
  always_comb begin
    any = |req;
    idx = '0;
    c   = '0;
    for (int k = NUM_CPU; k >= 1; k--) begin
      c = GW'((int'(last) + k) % NUM_CPU);
      if (req[c]) idx = c;
    end
  end
endmodule

// File: rtl/ace_ar_arbiter.sv
// ace_ar_arbiter: round-robin AR/R sharing with one outstanding read held until rack
// Optional R id checking is built when ACE_AR_ARBITER_ID_CHECK_EN is defined.
module ace_ar_arbiter
  import param_pkg::*;
#(
  parameter int NUM_CPU = 2,
  parameter int GW      = $clog2(NUM_CPU)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CPU-1:0]              m_ar_valid,
  output logic [NUM_CPU-1:0]              m_ar_ready,
  input  logic [NUM_CPU*ID_WIDTH-1:0]     m_ar_id,
  input  logic [NUM_CPU*ADDR_WIDTH-1:0]   m_ar_addr,
  input  logic [NUM_CPU*AR_CTRL_W-1:0]    m_ar_ctrl,
  output logic [NUM_CPU-1:0]              m_r_valid,
  input  logic [NUM_CPU-1:0]              m_r_ready,
  output logic [DATA_WIDTH-1:0]           m_r_data,
  output logic [RESP_WIDTH-1:0]           m_r_resp,
  output logic                            m_r_last,
  output logic [ID_WIDTH-1:0]             m_r_id,
  input  logic [NUM_CPU-1:0]              m_rack,
  output logic                            s_ar_valid,
  input  logic                            s_ar_ready,
  output logic [ID_WIDTH-1:0]             s_ar_id,
  output logic [ADDR_WIDTH-1:0]           s_ar_addr,
  output logic [AR_CTRL_W-1:0]            s_ar_ctrl,
  input  logic                            s_r_valid,
  output logic                            s_r_ready,
  input  logic [DATA_WIDTH-1:0]           s_r_data,
  input  logic [RESP_WIDTH-1:0]           s_r_resp,
  input  logic                            s_r_last,
  input  logic [ID_WIDTH-1:0]             s_r_id,
  output logic [NUM_CPU-1:0]              grant,
  output logic                            id_err
);
  arb_state_t state_q, state_d;
  logic [GW-1:0] g_q, g_d, last_q, last_d, idx;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AR_CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [NUM_CPU-1:0] g_oh, idx_oh;
  logic any, in_data, r_hs;
  rr_pick #(.NUM_CPU(NUM_CPU), .GW(GW)) u_pick (.req(m_ar_valid), .last(last_q), .any(any), .idx(idx));
  assign g_oh    = NUM_CPU'(1) << g_q;
  assign idx_oh  = NUM_CPU'(1) << idx;
  assign in_data = state_q == ARB_DATA;
  assign r_hs    = in_data && s_r_valid && s_r_ready;
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    last_d     = last_q;
    id_d       = id_q;
    addr_d     = addr_q;
    ctrl_d     = ctrl_q;
    m_ar_ready = '0;
    case (state_q)
      ARB_IDLE: if (any && !reset) begin
        m_ar_ready = idx_oh;
        g_d        = idx;
        id_d       = m_ar_id[idx*ID_WIDTH +: ID_WIDTH];
        addr_d     = m_ar_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
        ctrl_d     = m_ar_ctrl[idx*AR_CTRL_W +: AR_CTRL_W];
        state_d    = ARB_ADDR;
      end
      ARB_ADDR: if (s_ar_ready) state_d = ARB_DATA;
      ARB_DATA: if (r_hs && s_r_last) state_d = ARB_RACK;
      default:  if (m_rack[g_q]) begin
        last_d  = g_q;
        state_d = ARB_IDLE;
      end
    endcase
  end
  assign s_ar_valid = state_q == ARB_ADDR;
  assign s_ar_id    = s_ar_valid ? id_q : '0;
  assign s_ar_addr  = s_ar_valid ? addr_q : '0;
  assign s_ar_ctrl  = s_ar_valid ? ctrl_q : '0;
  assign s_r_ready  = in_data && m_r_ready[g_q];
  assign m_r_valid  = (in_data && s_r_valid) ? g_oh : '0;
  assign m_r_data   = in_data ? s_r_data : '0;
  assign m_r_resp   = in_data ? s_r_resp : '0;
  assign m_r_last   = in_data && s_r_last;
  assign m_r_id     = in_data ? s_r_id : '0;
  assign grant      = state_q == ARB_IDLE ? '0 : g_oh;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      g_q     <= '0;
      last_q  <= GW'(NUM_CPU - 1);
      id_q    <= '0;
      addr_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      ctrl_q  <= ctrl_d;
    end
  end
`ifdef ACE_AR_ARBITER_ID_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | (r_hs && s_r_id != id_q);
  end
  assign id_err = err_q;
`else
  assign id_err = 1'b0;
`endif
endmodule

// File: tb/tb_ace_ar_arbiter.sv
// tb_ace_ar_arbiter: randomized scoreboard bench with a transaction-level arbitration model
module tb_ace_ar_arbiter;
  import param_pkg::*;
  localparam int N = 3;
`ifdef ACE_AR_ARBITER_ID_CHECK_EN
  localparam bit ID_CHK = 1'b1;
`else
  localparam bit ID_CHK = 1'b0;
`endif
  logic clk = 1'b0, reset;
  logic [N-1:0] m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_rack, grant;
  logic [N*ID_WIDTH-1:0] m_ar_id;
  logic [N*ADDR_WIDTH-1:0] m_ar_addr;
  logic [N*AR_CTRL_W-1:0] m_ar_ctrl;
  logic [DATA_WIDTH-1:0] m_r_data, s_r_data;
  logic [RESP_WIDTH-1:0] m_r_resp, s_r_resp;
  logic [ID_WIDTH-1:0] m_r_id, s_ar_id, s_r_id;
  logic m_r_last, s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_r_last, id_err;
  logic [ADDR_WIDTH-1:0] s_ar_addr;
  logic [AR_CTRL_W-1:0] s_ar_ctrl;

  ace_ar_arbiter #(.NUM_CPU(N)) dut (
    .clk(clk), .reset(reset), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_ctrl(m_ar_ctrl),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .m_r_last(m_r_last), .m_r_id(m_r_id), .m_rack(m_rack),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr),
    .s_ar_ctrl(s_ar_ctrl), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last), .s_r_id(s_r_id), .grant(grant), .id_err(id_err)
  );

  typedef struct {int owner; logic [ID_WIDTH-1:0] id; logic [ADDR_WIDTH-1:0] addr; logic [AR_CTRL_W-1:0] ctrl;} ar_t;
  typedef struct {int owner; logic [DATA_WIDTH-1:0] data; logic [RESP_WIDTH-1:0] resp; logic last; logic [ID_WIDTH-1:0] id;} r_t;
  ar_t ar_q[$];
  r_t r_q[$];
  ar_t ma;
  r_t mr;
  int errors = 0, checks = 0, last_g = N - 1;
  bit exp_err = 1'b0;

  initial forever #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  // Next owner: first requester after the previous owner, wrapping around.
  function automatic int rr(input int last, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string p);
    chk({p, "_grant"}, grant, 0);
    chk({p, "_s_ar_valid"}, s_ar_valid, 0);
    chk({p, "_s_ar_addr"}, s_ar_addr, 0);
    chk({p, "_m_r_valid"}, m_r_valid, 0);
    chk({p, "_s_r_ready"}, s_r_ready, 0);
    chk({p, "_m_ar_ready"}, m_ar_ready, 0);
    chk({p, "_m_r_data"}, m_r_data, 0);
    chk({p, "_id_err"}, id_err, 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    m_r_ready = N'($urandom);
  end

  always @(negedge clk) if (!reset) begin
    if (s_ar_valid && s_ar_ready) begin
      if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
      else begin
        ma = ar_q.pop_front();
        chk("s_ar_addr", s_ar_addr, ma.addr);
        chk("s_ar_id", s_ar_id, ma.id);
        chk("s_ar_ctrl", s_ar_ctrl, ma.ctrl);
        chk("ar_hs_grant", grant, oh(ma.owner));
      end
    end
    chk("m_r_valid", m_r_valid, (r_q.size() > 0 && s_r_valid) ? oh(r_q[0].owner) : '0);
    if (r_q.size() > 0 && s_r_valid) chk("s_r_ready", s_r_ready, m_r_ready[r_q[0].owner]);
    for (int i = 0; i < N; i++) if (m_r_valid[i] && m_r_ready[i]) begin
      if (r_q.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        mr = r_q.pop_front();
        chk("r_owner", i, mr.owner);
        chk("r_data", m_r_data, mr.data);
        chk("r_resp", m_r_resp, mr.resp);
        chk("r_last", m_r_last, mr.last);
        chk("r_id", m_r_id, mr.id);
      end
    end
  end

  task automatic run_txn(input logic [N-1:0] mask, input int stall, input bit stray,
                         input bit fixed, input bit bad_id, input bit do_reset);
    ar_t req[N];
    ar_t e;
    r_t rb;
    int w, nb, t, o;
    cyc();
    for (int i = 0; i < N; i++) begin
      req[i].owner = i;
      req[i].id    = ID_WIDTH'($urandom);
      req[i].addr  = $urandom;
      req[i].ctrl  = {8'($urandom_range(0, 4)), 14'($urandom)};
    end
    if (fixed) begin
      req[0].id   = 4'd2;
      req[0].addr = 32'h1000;
      req[0].ctrl = {8'd3, 3'd3, 2'd1, 9'd0};
    end
    for (int i = 0; i < N; i++) begin
      m_ar_id[i*ID_WIDTH +: ID_WIDTH]       = req[i].id;
      m_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = req[i].addr;
      m_ar_ctrl[i*AR_CTRL_W +: AR_CTRL_W]   = req[i].ctrl;
    end
    m_ar_valid = mask;
    w = rr(last_g, mask);
    e = req[w];
    ar_q.push_back(e);
    t = 0;
    @(negedge clk);
    while (!m_ar_ready[w] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ar_ready_onehot", m_ar_ready, oh(w));
    @(posedge clk);
    #1 m_ar_valid = '0;
    @(negedge clk);
    chk("ar_latency", s_ar_valid, 1);
    chk("ar_grant", grant, oh(w));
    repeat (stall) begin
      @(negedge clk);
      chk("ar_stable_valid", s_ar_valid, 1);
      chk("ar_stable_addr", s_ar_addr, e.addr);
      chk("ar_stable_ctrl", s_ar_ctrl, e.ctrl);
    end
    cyc();
    s_ar_ready = 1'b1;
    cyc();
    s_ar_ready = 1'b0;
    nb = int'(e.ctrl[21:14]) + 1;
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 1)) cyc();
      rb.owner = w;
      rb.data  = {$urandom, $urandom};
      rb.resp  = RESP_WIDTH'($urandom);
      rb.last  = (b == nb - 1);
      rb.id    = (bad_id && b == 0) ? e.id + 1'b1 : e.id;
      s_r_valid = 1'b1;
      s_r_data  = rb.data;
      s_r_resp  = rb.resp;
      s_r_last  = rb.last;
      s_r_id    = rb.id;
      r_q.push_back(rb);
      t = 0;
      @(negedge clk);
      while (!s_r_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("r_handshake", s_r_ready, 1);
      @(posedge clk);
      #1 s_r_valid = 1'b0;
      if (bad_id && b == 0) exp_err = ID_CHK;
      if (do_reset && b == 1) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check_quiet("midreset");
        last_g = N - 1;
        exp_err = 1'b0;
        r_q.delete();
        ar_q.delete();
        return;
      end
    end
    if (stray) begin
      o = (w + 1) % N;
      m_rack[o] = 1'b1;
      m_ar_valid[o] = 1'b1;
      repeat (2) begin
        @(negedge clk);
        chk("rack_hold_grant", grant, oh(w));
        chk("rack_no_ready", m_ar_ready, 0);
      end
      cyc();
      m_rack = '0;
    end
    m_rack[w] = 1'b1;
    cyc();
    m_rack = '0;
    m_ar_valid = '0;
    last_g = w;
    @(negedge clk);
    chk("idle_grant", grant, 0);
    chk("id_err", id_err, exp_err);
  endtask

  initial begin
    reset = 1'b1;
    m_ar_valid = '0; m_ar_id = '0; m_ar_addr = '0; m_ar_ctrl = '0;
    m_r_ready = '0; m_rack = '0; s_ar_ready = 1'b0;
    s_r_valid = 1'b0; s_r_data = '0; s_r_resp = '0; s_r_last = 1'b0; s_r_id = '0;
    repeat (3) cyc();
    @(negedge clk);
    check_quiet("reset");
    cyc();
    reset = 1'b0;
    run_txn(3'b001, 0, 0, 1, 0, 0);
    repeat (4) run_txn(3'b011, 0, 0, 0, 0, 0);
    run_txn(3'b010, 5, 0, 0, 0, 0);
    run_txn(3'b001, 0, 1, 0, 0, 0);
    run_txn(3'b010, 0, 1, 0, 0, 0);
    run_txn(3'b011, 0, 0, 1, 0, 1);
    run_txn(3'b111, 0, 0, 0, 0, 0);
    run_txn(3'b101, 1, 0, 0, 0, 0);
    run_txn(3'b111, 0, 0, 0, 0, 0);
    run_txn(3'b001, 0, 0, 1, 1, 0);
    for (int i = 0; i < 30; i++)
      run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3), 1'($urandom), 0, 0, 0);
    repeat (2) cyc();
    chk("ar_q_empty", ar_q.size(), 0);
    chk("r_q_empty", r_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ace_ar_arbiter.md
Name: ace_ar_arbiter

Overview:
- Shares one downstream ACE read-address/read-data channel pair (AR/R) between NUM_CPU l1 controller instances.
- Sits between the per-CPU l1 controller AR/R/RACK ports and the interconnect's single read port.
- Round-robin arbitration with one outstanding read transaction system-wide.
- A grant is held from AR acceptance until the owning master asserts rack after the last R beat, which serialises coherent reads.

Parameters:
- NUM_CPU, 2: number of requesting l1 controllers; must be ≥2.
- GW, $clog2(NUM_CPU): width of the internal grant index.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_ar_valid  in  NUM_CPU  per-master AR valid
- m_ar_ready  out  NUM_CPU  per-master AR ready
- m_ar_id  in  NUM_CPU*ID_WIDTH  per-master AR id; slice i = bits [i*ID_WIDTH +: ID_WIDTH]
- m_ar_addr  in  NUM_CPU*ADDR_WIDTH  per-master AR address
- m_ar_ctrl  in  NUM_CPU*AR_CTRL_W  packed {len[7:0], size[2:0], burst[1:0], prot[2:0], snoop[3:0], domain[1:0]}
- m_r_valid  out  NUM_CPU  per-master R valid
- m_r_ready  in  NUM_CPU  per-master R ready
- m_r_data  out  DATA_WIDTH  R data, broadcast to all masters
- m_r_resp  out  RESP_WIDTH  R resp, broadcast
- m_r_last  out  1  R last, broadcast
- m_r_id  out  ID_WIDTH  R id, broadcast
- m_rack  in  NUM_CPU  per-master read acknowledge
- s_ar_valid / s_ar_ready  out / in  1  downstream AR handshake
- s_ar_id, s_ar_addr, s_ar_ctrl  out  ID_WIDTH, ADDR_WIDTH, AR_CTRL_W  downstream AR payload
- s_r_valid / s_r_ready  in / out  1  downstream R handshake
- s_r_data, s_r_resp, s_r_last, s_r_id  in  DATA_WIDTH, RESP_WIDTH, 1, ID_WIDTH  downstream R payload
- grant  out  NUM_CPU  one-hot owner of the channel; 0 in IDLE
- id_err  out  1  sticky R id mismatch flag

Behaviour:
- States: IDLE, ADDR, DATA, RACK.
- Reset:
  - state=IDLE, last_grant=NUM_CPU-1, so CPU0 has first priority.
  - Payload registers are cleared; all outputs are 0.
  - Reset asserted in any state aborts to IDLE the next cycle. No rack is awaited.
- IDLE:
  - If any m_ar_valid is set, pick the first requester searching from (last_grant+1) mod NUM_CPU upward with wrap-around.
  - Assert m_ar_ready[g]=1 combinationally in the same cycle.
  - Latch id/addr/ctrl slice g and g itself; go to ADDR.
  - No other master sees ready.
- ADDR:
  - s_ar_valid=1 with the latched payload. The payload is stable while s_ar_ready=0.
  - On s_ar_valid&&s_ar_ready, go to DATA.
  - Latency from master AR accept to s_ar_valid is exactly 1 cycle.
- DATA:
  - m_r_valid[g]=s_r_valid; all other m_r_valid bits are 0.
  - s_r_ready=m_r_ready[g], combinational passthrough, so there is zero added R latency.
  - Broadcast R fields equal the s_r_* fields.
  - On a handshaked beat with s_r_last=1, go to RACK. Beats with last=0 stay in DATA; the beat count is unconstrained.
- RACK:
  - Wait for m_rack[g]=1, then set last_grant=g and go to IDLE.
  - rack is counted only from the granted master; rack from others is ignored.
- grant is the one-hot of g in ADDR, DATA and RACK.
- No new AR is accepted outside IDLE, so the minimum gap between grants is 1 idle cycle.
- A single requester continuously requesting is re-granted on every IDLE visit.
- Simultaneous requests are served in strict rotation: with 3 requesters and last_grant=0, order is 1, 2, 0.

Optional Feature:
- Macro: ACE_AR_ARBITER_ID_CHECK_EN.
- Defined:
  - In DATA, a handshaked beat with s_r_id != latched id sets id_err=1.
  - id_err stays set until reset.
  - The beat is still forwarded to master g.
- Undefined: id_err is tied 0 and no comparator is built.

Decomposition:
- Add to param_pkg:
  - AR_CTRL_W=22.
  - arb_state_t enum {ARB_IDLE, ARB_ADDR, ARB_DATA, ARB_RACK}.
- One sub-module, rr_pick: purely combinational round-robin search.
  - Inputs: req[NUM_CPU], last[GW].
  - Outputs: any, idx[GW].

Test Plan:
- Single master, NUM_CPU=2:
  - Stimulus: CPU0 AR addr=0x1000, len=3; s_ar_ready=1; 4 R beats; rack on the cycle after last.
  - Required: m_ar_ready[0] pulses once; s_ar_addr=0x1000 one cycle later; 4 beats on m_r_valid[0] only; IDLE after rack.
- Contention:
  - Stimulus: both CPUs hold m_ar_valid from reset for 4 transactions.
  - Required: grant order CPU0, CPU1, CPU0, CPU1.
- Backpressure:
  - Stimulus: s_ar_ready=0 for 5 cycles; m_r_ready[1]=0 on beat 2.
  - Required: AR payload stable for 5 cycles; s_r_ready=0 while CPU1 stalls; no beat lost or duplicated.
- Rack gating:
  - Stimulus: CPU1 requests during CPU0's RACK wait; CPU1 asserts rack early.
  - Required: CPU1 is not granted until m_rack[0]; the stray rack is ignored.
- Mid-operation reset:
  - Stimulus: reset asserted in DATA after beat 1.
  - Required: next cycle all outputs are 0, state IDLE, CPU0 has priority.
- ID check, with the macro defined:
  - Stimulus: latched id=2, s_r_id=3 on beat 0.
  - Required: id_err=1 from the next cycle until reset; data still delivered.
